// File: rtl/motion_pkg.sv
// Shared types and defaults for the per-frame motion scheduler.
package motion_pkg;

  typedef enum logic [1:0] {IDLE, S_P, S_Z, S_X} sched_state_t;

  localparam int unsigned COOLDOWN_DEF = 4;
  localparam int unsigned CD_W_DEF     = 3;

endpackage

// File: rtl/jump_gate.sv
// Per-player jump request latch, airborne tracking and post-landing cooldown.
// MOTION_DOUBLE_JUMP_EN swaps the airborne bit for a 2-bit jump count.
module jump_gate
  import motion_pkg::*;
#(
  parameter int unsigned COOLDOWN = COOLDOWN_DEF,
  parameter int unsigned CD_W     = CD_W_DEF
) (
  input  logic CLK,
  input  logic Reset_n,
  input  logic req_lvl,
  input  logic grd_hit,
  input  logic step,
  output logic jump
);

  logic            lvl_q;
  logic            req;
  logic [CD_W-1:0] cd;
  logic            airborne;
  logic            can_jump;
  logic            accept;

`ifdef MOTION_DOUBLE_JUMP_EN
  logic [1:0] jc;
  assign airborne = (jc != 2'd0);
  assign can_jump = (jc < 2'd2);
`else
  logic air_q;
  assign airborne = air_q;
  assign can_jump = ~air_q;
`endif

  assign accept = req & can_jump & (cd == '0);
  assign jump   = step & accept;

  always_ff @(posedge CLK) begin
    // Level history tracks through reset so a held key is not seen as a fresh press.
    lvl_q <= req_lvl;
    if (!Reset_n) begin
      req <= 1'b0;
      cd  <= '0;
`ifdef MOTION_DOUBLE_JUMP_EN
      jc  <= 2'd0;
`else
      air_q <= 1'b0;
`endif
    end else begin
      req <= (req_lvl & ~lvl_q) | (req & ~step);
      if (step) begin
        if (accept) begin
`ifdef MOTION_DOUBLE_JUMP_EN
          jc <= jc + 2'd1;
`else
          air_q <= 1'b1;
`endif
        end else if (airborne && grd_hit) begin
`ifdef MOTION_DOUBLE_JUMP_EN
          jc <= 2'd0;
`else
          air_q <= 1'b0;
`endif
          cd <= CD_W'(COOLDOWN);
        end else if (cd != '0) begin
          cd <= cd - CD_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/motion_sched.sv
// Per-frame scheduler: strobes player, Zuofu, then X step; gates jumps; decodes keys.
// Optional feature macro: MOTION_DOUBLE_JUMP_EN (handled inside jump_gate).
module motion_sched
  import motion_pkg::*;
#(
  parameter int unsigned COOLDOWN = COOLDOWN_DEF,
  parameter int unsigned CD_W     = CD_W_DEF
) (
  input  logic CLK,
  input  logic Reset_n,
  input  logic frame_clk,
  input  logic key_p,
  input  logic switch_z,
  input  logic grd_hit_p,
  input  logic grd_hit_z,
  input  logic left_key,
  input  logic right_key,
  output logic step_p,
  output logic step_z,
  output logic step_x,
  output logic jump_p,
  output logic jump_z,
  output logic left_en,
  output logic right_en,
  output logic x_stop,
  output logic overrun
);

  sched_state_t state;
  logic         frame_q;
  logic         frame_edge;
  logic         pending;

  assign frame_edge = frame_clk & ~frame_q;

  always_ff @(posedge CLK) begin
    frame_q <= frame_clk;
    if (!Reset_n) begin
      state   <= IDLE;
      pending <= 1'b0;
      overrun <= 1'b0;
      step_p  <= 1'b0;
      step_z  <= 1'b0;
      step_x  <= 1'b0;
    end else begin
      step_p <= 1'b0;
      step_z <= 1'b0;
      step_x <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_edge || pending) begin
            state   <= S_P;
            step_p  <= 1'b1;
            pending <= 1'b0;
          end
        end
        S_P: begin
          state  <= S_Z;
          step_z <= 1'b1;
          if (frame_edge) begin
            if (pending) overrun <= 1'b1;
            pending <= 1'b1;
          end
        end
        S_Z: begin
          state  <= S_X;
          step_x <= 1'b1;
          if (frame_edge) begin
            if (pending) overrun <= 1'b1;
            pending <= 1'b1;
          end
        end
        S_X: begin
          // Chain straight into the next sequence; a second edge on top of pending is lost.
          if (frame_edge || pending) begin
            state   <= S_P;
            step_p  <= 1'b1;
            pending <= 1'b0;
            if (frame_edge && pending) overrun <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  jump_gate #(.COOLDOWN(COOLDOWN), .CD_W(CD_W)) u_gate_p (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .req_lvl (key_p),
    .grd_hit (grd_hit_p),
    .step    (step_p),
    .jump    (jump_p)
  );

  jump_gate #(.COOLDOWN(COOLDOWN), .CD_W(CD_W)) u_gate_z (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .req_lvl (switch_z),
    .grd_hit (grd_hit_z),
    .step    (step_z),
    .jump    (jump_z)
  );

  assign left_en  = step_x & left_key & ~right_key;
  assign right_en = step_x & right_key & ~left_key;
  assign x_stop   = step_x & ~(left_key ^ right_key);

endmodule

// File: tb/tb_motion_sched.sv
// Directed bench for motion_sched; expected values worked out by hand per frame.
module tb_motion_sched;

  logic CLK, Reset_n, frame_clk, key_p, switch_z, grd_hit_p, grd_hit_z;
  logic left_key, right_key;
  logic step_p, step_z, step_x, jump_p, jump_z, left_en, right_en, x_stop, overrun;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  motion_sched #(.COOLDOWN(4), .CD_W(3)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .key_p(key_p), .switch_z(switch_z),
    .grd_hit_p(grd_hit_p), .grd_hit_z(grd_hit_z),
    .left_key(left_key), .right_key(right_key),
    .step_p(step_p), .step_z(step_z), .step_x(step_x),
    .jump_p(jump_p), .jump_z(jump_z),
    .left_en(left_en), .right_en(right_en), .x_stop(x_stop),
    .overrun(overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [8:0] all_outs();
    return {step_p, step_z, step_x, jump_p, jump_z, left_en, right_en, x_stop, overrun};
  endfunction

  task automatic press_p;
    key_p = 1'b1; tick; key_p = 1'b0; tick;
  endtask

  task automatic press_z;
    switch_z = 1'b1; tick; switch_z = 1'b0; tick;
  endtask

  // xexp = {left_en, right_en, x_stop}
  task automatic run_frame(input string tag, input logic jp, input logic jz, input logic [2:0] xexp);
    frame_clk = 1'b1; tick; frame_clk = 1'b0;
    check({tag, ".step_p"}, {step_p, step_z, step_x}, 3'b100);
    check({tag, ".jump_p"}, jump_p, jp);
    tick;
    check({tag, ".step_z"}, {step_p, step_z, step_x}, 3'b010);
    check({tag, ".jump_z"}, jump_z, jz);
    tick;
    check({tag, ".step_x"}, {step_p, step_z, step_x}, 3'b001);
    check({tag, ".x_dec"}, {left_en, right_en, x_stop}, xexp);
    tick;
    check({tag, ".idle"}, {step_p, step_z, step_x}, 3'b000);
  endtask

  initial begin
    Reset_n = 1'b0; frame_clk = 1'b0; key_p = 1'b0; switch_z = 1'b0;
    grd_hit_p = 1'b0; grd_hit_z = 1'b0; left_key = 1'b0; right_key = 1'b0;

    // 1: reset and basic strobe order / latency
    tick; tick;
    check("reset_outs", all_outs(), 9'h000);
    Reset_n = 1'b1; tick;
    check("post_reset_outs", all_outs(), 9'h000);
    run_frame("f_basic", 1'b0, 1'b0, 3'b001);

    // 2: grounded jump accepted, press while airborne
    grd_hit_p = 1'b1;
    press_p; run_frame("jump1", 1'b1, 1'b0, 3'b001);
    grd_hit_p = 1'b0;
`ifdef MOTION_DOUBLE_JUMP_EN
    press_p; run_frame("jump2_dbl", 1'b1, 1'b0, 3'b001);
    press_p; run_frame("jump3_rej", 1'b0, 1'b0, 3'b001);
`else
    press_p; run_frame("jump2_rej", 1'b0, 1'b0, 3'b001);
`endif
    run_frame("dropped", 1'b0, 1'b0, 3'b001);

    // 3: landing then 4-frame cooldown
    grd_hit_p = 1'b1;
    run_frame("land", 1'b0, 1'b0, 3'b001);
    for (int i = 0; i < 4; i++) begin
      press_p; run_frame($sformatf("cool%0d", i), 1'b0, 1'b0, 3'b001);
    end
    press_p; run_frame("cool_done", 1'b1, 1'b0, 3'b001);
    grd_hit_p = 1'b0;
`ifdef MOTION_DOUBLE_JUMP_EN
    press_p; run_frame("jc_restart", 1'b1, 1'b0, 3'b001);
`else
    press_p; run_frame("air_again", 1'b0, 1'b0, 3'b001);
`endif

    // 5: X decode, plus a Zuofu jump
    grd_hit_z = 1'b1;
    left_key = 1'b1; right_key = 1'b1;
    press_z; run_frame("x_both", 1'b0, 1'b1, 3'b001);
    left_key = 1'b0;
    run_frame("x_right", 1'b0, 1'b0, 3'b010);
    left_key = 1'b1; right_key = 1'b0;
    run_frame("x_left", 1'b0, 1'b0, 3'b100);
    left_key = 1'b0;
    run_frame("x_none", 1'b0, 1'b0, 3'b001);

    // 4: edge during S_Z -> chained S_P at N+4; further edge while pending -> overrun
    frame_clk = 1'b1; tick;
    check("ov.sp1", step_p, 1'b1);
    frame_clk = 1'b0; tick;
    check("ov.sz1", step_z, 1'b1);
    frame_clk = 1'b1; tick;
    check("ov.sx1", step_x, 1'b1);
    check("ov.none1", overrun, 1'b0);
    frame_clk = 1'b0; tick;
    check("ov.chain_sp", step_p, 1'b1);
    check("ov.none2", overrun, 1'b0);
    frame_clk = 1'b1; tick;
    check("ov.sz2", step_z, 1'b1);
    frame_clk = 1'b0; tick;
    check("ov.sx2", step_x, 1'b1);
    check("ov.none3", overrun, 1'b0);
    frame_clk = 1'b1; tick;
    check("ov.sp3", step_p, 1'b1);
    check("ov.set", overrun, 1'b1);
    frame_clk = 1'b0; tick; tick; tick;
    check("ov.lost_edge", {step_p, step_z, step_x}, 3'b000);
    tick;
    check("ov.sticky", overrun, 1'b1);

    // 6: reset in S_Z aborts the sequence
    frame_clk = 1'b1; tick; frame_clk = 1'b0;
    check("rst.sp", step_p, 1'b1);
    tick;
    check("rst.sz", step_z, 1'b1);
    Reset_n = 1'b0; tick;
    check("rst.abort", all_outs(), 9'h000);
    Reset_n = 1'b1; tick;
    check("rst.quiet1", all_outs(), 9'h000);
    tick;
    check("rst.quiet2", all_outs(), 9'h000);
    run_frame("rst.recover", 1'b0, 1'b0, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
